mailbox_status_wr: RTL
======================

# mailbox_status_wr

- Posts per-channel completion words into the shared PS/PL BRAM mailbox through a BRAM controller port; the PS side polls this mailbox.
- Each channel has a pending flag, a 16-bit post counter and a fixed mailbox slot. A round-robin arbiter picks one pending channel at a time.
- Every write is read back and compared, with bounded retry.
- The block sits beside the Unet wrapper control logic and is the posting end of the mailbox handshake the PS consumes.

## Interface

Parameters:
- START_ADDR, 32'h4580_0000, byte address of channel 0 slot
- OFFSET_CONST, 32'h0000_0004, byte stride between channel slots
- SIG_LO, 16'h0030, constant low half of every posted word
- MAX_RETRY, 3, readback-mismatch retries before giving up on a post

Ports:
- clk  in  1  single clock, also forwarded as ram_clk
- rst  in  1  synchronous, active-high reset
- ram_clk  out  1  = clk
- ram_rst  out  1  constant 0
- ram_addr  out  32  BRAM byte address
- ram_en  out  1  BRAM enable
- ram_we  out  4  byte write enables
- ram_wd_data  out  32  write data
- ram_rd_data  in  32  read data, 1-cycle BRAM read latency
- ch_done  in  8  per-channel completion pulses, any number may be high in the same cycle
- seq_clear  in  1  clears all post counters
- post_onehot  out  8  one-cycle pulse on the channel whose post verified
- overflow  out  8  sticky: ch_done arrived while that channel was already pending
- err  out  8  sticky: post dropped after MAX_RETRY mismatches
- wr_busy  out  1  FSM not in IDLE

## Operation

- **Pending bits**
  - A ch_done[i] pulse sets pending[i].
  - If pending[i] is already 1, overflow[i] also sets. No second post is queued.
- **Grant (IDLE with pending != 0)**
  - The round-robin arbiter picks the first pending channel at or above rr_ptr, wrapping 7 to 0.
  - At grant: pending[ch] clears, ch is latched, rr_ptr becomes ch+1 mod 8, and cnt[ch] increments.
  - Word latched: {cnt_next[15:0], SIG_LO}. Address latched: START_ADDR + ch*OFFSET_CONST (32-bit, modulo 2^32).
  - A ch_done on the in-service channel after grant sets pending again and is served later. It is not an overflow.
- **Counter rule**
  - A counter starts at 0, so the first post after reset or seq_clear carries 16'h0001.
  - 16'hFFFF increments to 16'h0001. Posted count 0 never occurs.
- **FSM states** (each state lasts one cycle)
  - IDLE: on grant, go to WRITE.
  - WRITE: ram_en=1, ram_we=4'hF, addr and data driven; go to READ.
  - READ: ram_en=1, ram_we=0, same addr; go to WAIT.
  - WAIT: register ram_rd_data; go to CHECK.
  - CHECK, match: post_onehot[ch]=1, retry cleared, go to IDLE.
  - CHECK, mismatch with retry < MAX_RETRY: retry+1, go to WRITE with the same word. The counter does not re-increment.
  - CHECK, mismatch with retry = MAX_RETRY: err[ch]=1, retry cleared, go to IDLE. The counter keeps the incremented value.
- **seq_clear**
  - Zeroes all counters the next cycle. The in-flight word is unaffected.
  - If seq_clear coincides with a grant, the grant's increment wins for that channel: the counter ends at 1 and the post carries 1.
- **Reset mid-operation**
  - The FSM returns to IDLE and pending, counters, rr_ptr, overflow and err clear.
  - The partial BRAM write is not undone.

## Timing

- **Reset values:** ram_addr=START_ADDR, ram_en=0, ram_we=0, ram_wd_data=0, post_onehot=0, overflow=0, err=0, wr_busy=0, rr_ptr=0.
- **Latency:** ch_done pulse at cycle t gives pending at t+1, grant in IDLE at t+1, WRITE at t+2, READ at t+3, WAIT at t+4, CHECK with post_onehot at t+5, IDLE at t+6.
- **Throughput:** 5 cycles per clean post. Each retry adds 4 cycles.
- **Outside WRITE/READ:** ram_en=0 and ram_we=0. ram_addr and ram_wd_data hold their last value.
- **Outputs:** post_onehot is at most one-hot and only high in CHECK. overflow and err clear only on rst.

## Structure

- Package mailbox_pkg holds:
  - state encodings IDLE/WRITE/READ/WAIT/CHECK
  - field positions CNT_MSB=31, CNT_LSB=16
  - NUM_CH=8
- Sub-module rr_arbiter8:
  - inputs: 8-bit request, 3-bit pointer
  - outputs: grant valid, 3-bit index
  - purely combinational

## Test plan

- Single post: ch_done=8'h01 at t, BRAM model echoes the write. Expect a write of 32'h0001_0030 to 32'h4580_0000 at t+2, post_onehot=8'h01 at t+5, then a second ch0 post carrying 32'h0002_0030.
- Simultaneous: ch_done=8'h81. Expect ch0 served first (addr 4580_0000), then ch7 (addr 4580_001C). Both words carry 0001_0030.
- Overflow: ch_done[3] pulsed twice before grant. Expect overflow=8'h08 and only one post; pulsed again during service, expect a second post with count 2 and overflow unchanged.
- Retry: BRAM model corrupts the readback on the first 2 reads. Expect 3 writes and post_onehot at t+13; corrupt 4 reads and expect err[ch] set with no post_onehot.
- Wrap/clear: preload cnt[2]=16'hFFFF and post, expect 32'h0001_0030 to 4580_0008. Then seq_clear followed by a ch2 post, expect 32'h0001_0030.
- Reset mid-post: assert rst during READ. Expect all outputs at reset values the next cycle and no post_onehot.

Source files
------------

// File: rtl/mailbox_pkg.sv
// Shared types and constants for the PS/PL mailbox status writer.
package mailbox_pkg;
  localparam int NUM_CH  = 8;
  localparam int CNT_MSB = 31;
  localparam int CNT_LSB = 16;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, CHECK} state_t;

  // Posted counts skip zero so the PS can treat 0 as "never posted".
  function automatic logic [15:0] cnt_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? 16'h0001 : c + 16'h0001;
  endfunction

  function automatic logic [31:0] pack_word(input logic [15:0] c, input logic [15:0] lo);
    logic [31:0] w;
    w = {16'h0000, lo};
    w[CNT_MSB:CNT_LSB] = c;
    return w;
  endfunction
endpackage

// File: rtl/rr_arbiter8.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter8
  import mailbox_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        ptr,
  output logic              gnt_vld,
  output logic [2:0]        gnt_idx
);
  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[ptr + 3'(i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = ptr + 3'(i);
      end
    end
  end
endmodule

// File: rtl/mailbox_status_wr.sv
// Posts per-channel completion words into the PS/PL BRAM mailbox and
// verifies each write by readback, retrying a bounded number of times.
module mailbox_status_wr
  import mailbox_pkg::*;
#(
  parameter logic [31:0] START_ADDR   = 32'h4580_0000,
  parameter logic [31:0] OFFSET_CONST = 32'h0000_0004,
  parameter logic [15:0] SIG_LO       = 16'h0030,
  parameter int          MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ram_clk,
  output logic              ram_rst,
  output logic [31:0]       ram_addr,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wd_data,
  input  logic [31:0]       ram_rd_data,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic              seq_clear,
  output logic [NUM_CH-1:0] post_onehot,
  output logic [NUM_CH-1:0] overflow,
  output logic [NUM_CH-1:0] err,
  output logic              wr_busy
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t                   state;
  logic [NUM_CH-1:0]        pending;
  logic [NUM_CH-1:0][15:0]  cnt;
  logic [2:0]               rr_ptr;
  logic [2:0]               ch;
  logic [RW-1:0]            retry;
  logic                     match_q;

  logic                     gnt_vld;
  logic [2:0]               gnt_idx;
  logic                     grant;
  logic [NUM_CH-1:0]        gnt_mask;
  logic [15:0]              cnt_nxt;

  assign ram_clk = clk;
  assign ram_rst = 1'b0;
  assign wr_busy = (state != IDLE);

  rr_arbiter8 u_arb (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign grant    = (state == IDLE) && gnt_vld;
  assign gnt_mask = grant ? (NUM_CH'(1) << gnt_idx) : '0;
  // A clear in the grant cycle restarts the granted channel from zero.
  assign cnt_nxt  = cnt_inc(seq_clear ? 16'h0000 : cnt[gnt_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      cnt         <= '0;
      rr_ptr      <= '0;
      ch          <= '0;
      retry       <= '0;
      match_q     <= 1'b0;
      ram_addr    <= START_ADDR;
      ram_en      <= 1'b0;
      ram_we      <= 4'h0;
      ram_wd_data <= '0;
      post_onehot <= '0;
      overflow    <= '0;
      err         <= '0;
    end else begin
      // The granted channel's bit is free again, so a pulse on it re-arms
      // rather than counting as an overflow.
      pending     <= (pending & ~gnt_mask) | ch_done;
      overflow    <= overflow | (ch_done & pending & ~gnt_mask);
      post_onehot <= '0;
      if (seq_clear) cnt <= '0;
      if (grant)     cnt[gnt_idx] <= cnt_nxt;

      case (state)
        IDLE: begin
          if (gnt_vld) begin
            ch          <= gnt_idx;
            rr_ptr      <= gnt_idx + 3'd1;
            ram_addr    <= START_ADDR + 32'(gnt_idx) * OFFSET_CONST;
            ram_wd_data <= pack_word(cnt_nxt, SIG_LO);
            ram_en      <= 1'b1;
            ram_we      <= 4'hF;
            state       <= WRITE;
          end
        end
        WRITE: begin
          ram_we <= 4'h0;
          state  <= READ;
        end
        READ: begin
          ram_en <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // Readback is captured as a compare result so CHECK's outputs
          // (post pulse / error) can be registered into the CHECK cycle.
          match_q <= (ram_rd_data == ram_wd_data);
          if (ram_rd_data == ram_wd_data)
            post_onehot <= NUM_CH'(1) << ch;
          else if (retry == RETRY_MAX)
            err[ch] <= 1'b1;
          state <= CHECK;
        end
        CHECK: begin
          if (match_q || retry == RETRY_MAX) begin
            retry <= '0;
            state <= IDLE;
          end else begin
            retry  <= retry + RW'(1);
            ram_en <= 1'b1;
            ram_we <= 4'hF;
            state  <= WRITE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
